// File: rtl/data_memory_pkg.sv
// Shared defaults, address layout and FSM state encoding for the line-wide data memory.
package data_memory_pkg;

    localparam int DM_DEPTH    = 512;
    localparam int DM_WIDTH    = 256;
    localparam int DM_LATENCY  = 10;
    localparam int DM_OFFSET_W = 5;   // 32-byte lines

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dm_state_e;

endpackage

// File: rtl/data_memory.sv
// Fixed-latency line memory: one request in flight, ack pulses LATENCY-1 cycles after
// acceptance, writes commit on the edge that ends the ack cycle.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH   = DM_DEPTH,
    parameter int WIDTH   = DM_WIDTH,
    parameter int LATENCY = DM_LATENCY
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      addr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    input  logic             write_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    logic [WIDTH-1:0] memory [0:DEPTH-1];

    dm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             wr_q,    wr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic [IDX_W-1:0] req_idx;
    logic             ack_last;
    logic             unused_addr;

    // Offset and everything above the 16 KB window are dropped, so addresses alias.
    assign req_idx     = addr_i[DM_OFFSET_W +: IDX_W];
    assign unused_addr = ^{addr_i[31:DM_OFFSET_W+IDX_W], addr_i[DM_OFFSET_W-1:0]};
    assign ack_last    = (state_q == BUSY) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    idx_d   = req_idx;
                    wr_d    = write_i;
                    wdata_d = data_i;
                end
            end
            BUSY: begin
                if (ack_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Data out shows the addressed line during any ack, so a write's ack exposes the old value.
    always_comb begin
        ack_o  = ack_last;
        data_o = '0;
        if (ack_last) begin
            data_o = memory[idx_q];
        end
    end

    // No reset here: contents survive rst_i, and an aborted write never reaches ack_last.
    always_ff @(posedge clk_i) begin
        if (ack_last && wr_q) begin
            memory[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: expected ack data and acceptance cycle are queued at
// request time and checked by a negedge monitor; a local line model tracks contents.
module tb_data_memory;

    localparam int W = 256;
    localparam int D = 512;
    localparam int L = 10;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  addr_i = '0;
    logic [W-1:0] data_i = '0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic         ack_o;
    logic [W-1:0] data_o;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    exp_t         q[$];
    exp_t         e;
    logic [W-1:0] model [0:D-1];

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[13:5]);
    endfunction

    function automatic logic [W-1:0] rnd_line();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic preload(input int i, input logic [W-1:0] v);
        dut.memory[i] = v;
        model[i]      = v;
    endtask

    // Outside reset: every ack must match the queue head in data and timing, else data_o is 0.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ack_o) begin
                if (q.size() == 0) begin
                    chk("unexp_ack", W'(ack_o), '0);
                end else begin
                    e = q.pop_front();
                    chk("ack_data", data_o, e.data);
                    chk("ack_lat", W'(cyc - e.acc), W'(L - 1));
                end
            end else begin
                chk("idle_data", data_o, '0);
            end
        end
    end

    task automatic wait_drain(input string tag);
        for (int i = 0; i < L + 4 && q.size() != 0; i++) @(posedge clk_i);
        chk(tag, W'(q.size()), '0);
        q.delete();
        #1;
    endtask

    task automatic do_req(input logic [31:0] a, input logic w, input logic [W-1:0] d);
        int ix;
        exp_t r;
        ix = idx(a);
        @(negedge clk_i);
        addr_i = a; write_i = w; data_i = d; enable_i = 1'b1;
        @(posedge clk_i); #1;
        r.data = model[ix];
        r.acc  = cyc;
        q.push_back(r);
        if (w) model[ix] = d;
        enable_i = 1'b0;
        addr_i   = $urandom;
        data_i   = rnd_line();
        write_i  = 1'($urandom);
        wait_drain("ack_seen");
    endtask

    // enable_i held high; inputs scrambled mid-BUSY must not affect the latched request.
    task automatic burst();
        logic [31:0] addrs [3];
        exp_t r;
        addrs[0] = 32'h0060; addrs[1] = 32'h0080; addrs[2] = 32'h00A0;
        @(negedge clk_i);
        enable_i = 1'b1; write_i = 1'b0; addr_i = addrs[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            r.data = model[idx(addrs[k])];
            r.acc  = cyc;
            q.push_back(r);
            repeat (4) @(posedge clk_i);
            #1;
            addr_i = $urandom; write_i = 1'b1; data_i = rnd_line();
            repeat (L - 4) @(posedge clk_i);
            @(negedge clk_i);
            write_i = 1'b0;
            if (k < 2) addr_i = addrs[k+1];
            else enable_i = 1'b0;
        end
        wait_drain("burst_seen");
    endtask

    initial begin
        logic [W-1:0] x, y, z, a5;
        logic [31:0]  ra;
        int           acc;

        for (int i = 0; i < D; i++) preload(i, rnd_line());
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ack", W'(ack_o), '0);
        chk("rst_data", data_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // basic read of a preloaded line
        preload(0, 256'h5);
        do_req(32'h0, 1'b0, '0);

        // write then read back; write ack shows the old line
        a5 = {32{8'hA5}};
        do_req(32'h0400, 1'b1, a5);
        chk("wr_commit", dut.memory[32], a5);
        do_req(32'h0400, 1'b0, '0);

        // offset ignored and upper bits wrap
        x = rnd_line(); y = rnd_line();
        preload(0, x); preload(1, y);
        do_req(32'h001F, 1'b0, '0);
        do_req(32'h4020, 1'b0, '0);

        // reset mid-BUSY aborts the write
        z = rnd_line();
        preload(2, z);
        @(negedge clk_i);
        addr_i = 32'h0040; write_i = 1'b1; data_i = rnd_line(); enable_i = 1'b1;
        @(posedge clk_i); #1;
        acc = cyc;
        enable_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("abort_ack", W'(ack_o), '0);
        chk("abort_data", data_o, '0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("abort_ack2", W'(ack_o), '0);
        chk("abort_data2", data_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (L + 2) @(posedge clk_i);
        #1;
        chk("abort_mem", dut.memory[2], z);
        chk("abort_cyc", W'(cyc - acc > L), W'(1));
        do_req(32'h0040, 1'b0, '0);

        // back-to-back with enable held high
        burst();

        // random mix against the line model
        for (int i = 0; i < 10; i++) begin
            ra = $urandom & 32'hFFFF_07FF;
            do_req(ra, 1'($urandom), rnd_line());
        end
        for (int i = 0; i < 4; i++) do_req(32'h0000_0400 + 32'(i * 32), 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
